// File: rtl/axi_wr_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : axi_wr_responder_if
// AXI4 write channels (AW/W/B) plus the beat-level memory write port.
// Rev    : 1.0
// ============================================================================
interface axi_wr_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic [2:0]            awprot;
  logic [3:0]            awcache;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [STRB_W-1:0]     mem_wstrb;

  modport slave (
    input  awaddr, awlen, awsize, awburst, awprot, awcache, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    output mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output awaddr, awlen, awsize, awburst, awprot, awcache, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    input  mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface
`default_nettype wire

// File: rtl/axi_wr_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : axi_wr_responder
// AXI4 write responder: one burst at a time, one registered memory write per beat.
// Rev    : 1.0
// ============================================================================
module axi_wr_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic         axi_aclk,
  input  wire logic         axi_reset,
  axi_wr_responder_if.slave bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  logic [1:0]            state_q,     state_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [7:0]            len_q,       len_d;
  logic [2:0]            size_q,      size_d;
  logic [1:0]            burst_q,     burst_d;
  logic [7:0]            beat_cnt_q,  beat_cnt_d;
  logic                  err_q,       err_d;
  logic                  mem_we_q,    mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]     mem_wstrb_q, mem_wstrb_d;

  logic [ADDR_WIDTH-1:0] w_aw_bytes;
  logic                  w_aw_err;
  logic [ADDR_WIDTH-1:0] w_size_bytes;
  logic [ADDR_WIDTH-1:0] w_wrap_bytes;
  logic [ADDR_WIDTH-1:0] w_wrap_low;
  logic [ADDR_WIDTH-1:0] w_wrap_next;
  logic [ADDR_WIDTH-1:0] w_incr_next;
  logic [ADDR_WIDTH-1:0] w_beat_addr;

  // Protection and cache attributes carry no meaning for this memory.
  logic unused_attr;
  assign unused_attr = ^{bus.awprot, bus.awcache};

  assign w_aw_bytes = ADDR_WIDTH'(1) << bus.awsize;
  assign w_aw_err   = (bus.awburst == 2'b11)
                   || (bus.awsize > MAX_SIZE)
                   || ((bus.awburst == BURST_WRAP)
                       && !(bus.awlen == 8'd1 || bus.awlen == 8'd3 ||
                            bus.awlen == 8'd7 || bus.awlen == 8'd15))
                   || ((bus.awburst == BURST_WRAP)
                       && ((bus.awaddr & (w_aw_bytes - ADDR_WIDTH'(1))) != '0));

  assign w_size_bytes = ADDR_WIDTH'(1) << size_q;
  assign w_wrap_bytes = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
  assign w_wrap_low   = addr_q & ~(w_wrap_bytes - ADDR_WIDTH'(1));
  assign w_wrap_next  = ((addr_q + w_size_bytes) == (w_wrap_low + w_wrap_bytes))
                      ? w_wrap_low : (addr_q + w_size_bytes);
  // First INCR beat may be unaligned; later beats snap to the transfer size.
  assign w_incr_next  = (addr_q & ~(w_size_bytes - ADDR_WIDTH'(1))) + w_size_bytes;
  assign w_beat_addr  = addr_q & ~ADDR_WIDTH'(STRB_W - 1);

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.awvalid) begin
          addr_d     = bus.awaddr;
          len_d      = bus.awlen;
          size_d     = bus.awsize;
          burst_d    = bus.awburst;
          beat_cnt_d = 8'd0;
          err_d      = w_aw_err;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.wvalid) begin
          mem_we_d = !err_q;
          if (!err_q) begin
            mem_addr_d  = w_beat_addr;
            mem_wdata_d = bus.wdata;
            mem_wstrb_d = bus.wstrb;
          end
          unique case (burst_q)
            BURST_INCR: addr_d = w_incr_next;
            BURST_WRAP: addr_d = w_wrap_next;
            default:    addr_d = addr_q;
          endcase
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (bus.wlast != (beat_cnt_q == len_q)) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (bus.wlast) begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (bus.bready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced low in the cycle reset is sampled, not only the next one.
  always_comb begin
    bus.awready   = 1'b0;
    bus.wready    = 1'b0;
    bus.bvalid    = 1'b0;
    bus.bresp     = 2'b00;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    if (!axi_reset) begin
      bus.awready   = (state_q == S_IDLE);
      bus.wready    = (state_q == S_DATA);
      bus.bvalid    = (state_q == S_RESP);
      bus.bresp     = ((state_q == S_RESP) && err_q) ? 2'b10 : 2'b00;
      bus.mem_we    = mem_we_q;
      bus.mem_addr  = mem_addr_q;
      bus.mem_wdata = mem_wdata_q;
      bus.mem_wstrb = mem_wstrb_q;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_axi_wr_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_axi_wr_responder
// Scenario tasks with a queue of expected memory writes drained every cycle.
// Rev    : 1.0
// ============================================================================
module tb_axi_wr_responder;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_wr_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_wr_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .axi_aclk  (clk),
    .axi_reset (rst),
    .bus       (bus.slave)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    int            due;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  // Advance one clock, sample 1ns after the edge, and retire due writes.
  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected actual addr=%h data=%h strb=%h required no write",
                 bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
      end else begin
        e = exp_q.pop_front();
        if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data ||
            bus.mem_wstrb !== e.strb || cyc !== e.due) begin
          errors++;
          $display("FAIL wr_beat actual addr=%h data=%h strb=%h cyc=%0d required addr=%h data=%h strb=%h cyc=%0d",
                   bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, cyc,
                   e.addr, e.data, e.strb, e.due);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL wr_missing actual mem_we=%b required write addr=%h at cyc=%0d",
               bus.mem_we, exp_q[0].addr, exp_q[0].due);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic send_aw(input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bus.awaddr  = addr;
    bus.awlen   = len;
    bus.awsize  = size;
    bus.awburst = burst;
    bus.awprot  = 3'($urandom);
    bus.awcache = 4'($urandom);
    bus.awvalid = 1'b1;
    while (bus.awready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (bus.awready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL aw_timeout actual awready=%b required 1", bus.awready);
    end
    step();
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] data, input logic [SW-1:0] strb,
                        input logic last, input bit exp_wr, input logic [AW-1:0] addr);
    int  n = 0;
    wr_t e;
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.wlast  = last;
    bus.wvalid = 1'b1;
    while (bus.wready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (bus.wready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL w_timeout actual wready=%b required 1", bus.wready);
    end
    if (exp_wr) begin
      e.addr = addr;
      e.data = data;
      e.strb = strb;
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
    step();
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  task automatic get_b(input logic [1:0] exp_resp, input int hold);
    int n = 0;
    bus.bready = 1'b0;
    while (bus.bvalid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    for (int i = 0; i < hold; i++) begin
      step();
      checks++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== exp_resp) begin
        errors++;
        $display("FAIL b_hold actual bvalid=%b bresp=%b required bvalid=1 bresp=%b",
                 bus.bvalid, bus.bresp, exp_resp);
      end
    end
    checks++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== exp_resp) begin
      errors++;
      $display("FAIL b_resp actual bvalid=%b bresp=%b required bvalid=1 bresp=%b",
               bus.bvalid, bus.bresp, exp_resp);
    end
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    checks++;
    if (bus.awready !== 1'b1 || bus.bvalid !== 1'b0) begin
      errors++;
      $display("FAIL b_to_idle actual awready=%b bvalid=%b required awready=1 bvalid=0",
               bus.awready, bus.bvalid);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained actual pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if (bus.awready !== 1'b0 || bus.wready !== 1'b0 || bus.bvalid !== 1'b0 ||
        bus.bresp !== 2'b00 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 ||
        bus.mem_wdata !== '0 || bus.mem_wstrb !== '0) begin
      errors++;
      $display("FAIL reset_outputs actual aw=%b w=%b b=%b resp=%b we=%b addr=%h required all zero",
               bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.mem_we, bus.mem_addr);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.awready !== 1'b1 || bus.wready !== 1'b0 || bus.bvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release actual aw=%b w=%b b=%b required aw=1 w=0 b=0",
               bus.awready, bus.wready, bus.bvalid);
    end
  endtask

  task automatic test_incr();
    send_aw(32'h1000, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++)
      send_w($urandom, 4'hF, i == 3, 1'b1, 32'h1000 + 32'(4 * i));
    get_b(2'b00, 0);
    check_drained("incr");
  endtask

  task automatic test_wrap();
    logic [AW-1:0] addrs [4];
    addrs = '{32'h2008, 32'h200C, 32'h2000, 32'h2004};
    send_aw(32'h2008, 8'd3, 3'd2, 2'b10);
    for (int i = 0; i < 4; i++)
      send_w($urandom, 4'hF, i == 3, 1'b1, addrs[i]);
    get_b(2'b00, 0);
    check_drained("wrap");
  endtask

  task automatic test_fixed();
    logic [SW-1:0] strbs [3];
    strbs = '{4'hF, 4'h3, 4'h8};
    send_aw(32'h3004, 8'd2, 3'd2, 2'b00);
    for (int i = 0; i < 3; i++)
      send_w($urandom, strbs[i], i == 2, 1'b1, 32'h3004);
    get_b(2'b00, 0);
    check_drained("fixed");
  endtask

  task automatic test_unaligned();
    logic [AW-1:0] addrs [4];
    // Halfword INCR: two beats land in each 32-bit word.
    addrs = '{32'h9000, 32'h9000, 32'h9004, 32'h9004};
    send_aw(32'h9000, 8'd3, 3'd1, 2'b01);
    for (int i = 0; i < 4; i++)
      send_w($urandom, 4'hF, i == 3, 1'b1, addrs[i]);
    get_b(2'b00, 0);
    // Unaligned word INCR: first beat aligned down, then snapped upwards.
    addrs = '{32'h8000, 32'h8004, 32'h8008, 32'h0};
    send_aw(32'h8002, 8'd2, 3'd2, 2'b01);
    for (int i = 0; i < 3; i++)
      send_w($urandom, 4'hF, i == 2, 1'b1, addrs[i]);
    get_b(2'b00, 0);
    check_drained("unaligned");
  endtask

  task automatic test_early_wlast();
    send_aw(32'h4000, 8'd3, 3'd2, 2'b01);
    send_w($urandom, 4'hF, 1'b0, 1'b1, 32'h4000);
    send_w($urandom, 4'hF, 1'b1, 1'b1, 32'h4004);
    get_b(2'b10, 0);
    check_drained("early_wlast");
  endtask

  task automatic test_late_wlast();
    send_aw(32'h7000, 8'd1, 3'd2, 2'b01);
    send_w($urandom, 4'hF, 1'b0, 1'b1, 32'h7000);
    send_w($urandom, 4'hF, 1'b0, 1'b1, 32'h7004);
    get_b(2'b10, 0);
    check_drained("late_wlast");
  endtask

  task automatic test_bad_burst();
    send_aw(32'h4800, 8'd1, 3'd2, 2'b11);
    send_w($urandom, 4'hF, 1'b0, 1'b0, 32'h0);
    send_w($urandom, 4'hF, 1'b1, 1'b0, 32'h0);
    get_b(2'b10, 5);
    // Transfer wider than the bus is rejected too.
    send_aw(32'h4900, 8'd0, 3'd3, 2'b01);
    send_w($urandom, 4'hF, 1'b1, 1'b0, 32'h0);
    get_b(2'b10, 0);
    // Misaligned WRAP start.
    send_aw(32'h4A02, 8'd1, 3'd2, 2'b10);
    send_w($urandom, 4'hF, 1'b0, 1'b0, 32'h0);
    send_w($urandom, 4'hF, 1'b1, 1'b0, 32'h0);
    get_b(2'b10, 0);
    check_drained("bad_burst");
  endtask

  task automatic test_reset_mid();
    send_aw(32'h5000, 8'd3, 3'd2, 2'b01);
    send_w($urandom, 4'hF, 1'b0, 1'b1, 32'h5000);
    send_w($urandom, 4'hF, 1'b0, 1'b1, 32'h5004);
    rst = 1'b1;
    step();
    checks++;
    if (bus.wready !== 1'b0 || bus.bvalid !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_during actual w=%b b=%b we=%b required 0 0 0",
               bus.wready, bus.bvalid, bus.mem_we);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.awready !== 1'b1 || bus.wready !== 1'b0 || bus.bvalid !== 1'b0 ||
        bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after actual aw=%b w=%b b=%b we=%b required 1 0 0 0",
               bus.awready, bus.wready, bus.bvalid, bus.mem_we);
    end
    send_aw(32'h6000, 8'd1, 3'd2, 2'b01);
    send_w($urandom, 4'hF, 1'b0, 1'b1, 32'h6000);
    send_w($urandom, 4'hF, 1'b1, 1'b1, 32'h6004);
    get_b(2'b00, 0);
    check_drained("reset_mid");
  endtask

  initial begin
    bus.awaddr  = '0;
    bus.awlen   = '0;
    bus.awsize  = '0;
    bus.awburst = '0;
    bus.awprot  = '0;
    bus.awcache = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wlast   = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    step();
    test_reset();
    test_incr();
    test_wrap();
    test_fixed();
    test_unaligned();
    test_early_wlast();
    test_late_wlast();
    test_bad_burst();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
